// File: rtl/student_iis_rx_fifo_if.sv
// Bus bundle between the IIS receiver path, the stereo RX FIFO and the FIR consumer.
// The FIFO side uses the slave modport; the producer/consumer side uses master.
interface student_iis_rx_fifo_if #(
   parameter int DATA_SIZE = 16,
   parameter int DEPTH     = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [DATA_SIZE-1:0] Data_I_L;
   logic [DATA_SIZE-1:0] Data_I_R;
   logic                 valid_strobe_I;
   logic                 ready_i;
   logic                 clear_i;
   logic [DATA_SIZE-1:0] Data_O_L;
   logic [DATA_SIZE-1:0] Data_O_R;
   logic                 valid_o;
   logic [LW-1:0]        level_o;
   logic                 overflow_o;
   logic                 underflow_o;

   modport master (
      output Data_I_L, Data_I_R, valid_strobe_I, ready_i, clear_i,
      input  Data_O_L, Data_O_R, valid_o, level_o, overflow_o, underflow_o
   );

   modport slave (
      input  Data_I_L, Data_I_R, valid_strobe_I, ready_i, clear_i,
      output Data_O_L, Data_O_R, valid_o, level_o, overflow_o, underflow_o
   );
endinterface

// File: rtl/student_iis_rx_fifo.sv
// First-word-fall-through FIFO of stereo sample pairs with registered head outputs,
// level count and sticky overflow/underflow flags.
module student_iis_rx_fifo #(
   parameter int DATA_SIZE = 16,
   parameter int DEPTH     = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   student_iis_rx_fifo_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int PAIR_W = 2 * DATA_SIZE;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   // Handshake: a push is a one-cycle valid_strobe_I pulse with no back-pressure
   // (dropped and flagged when full); a pop happens on any edge where valid_o and
   // ready_i are both 1; ready_i while valid_o=0 pops nothing and flags underflow.

   logic [PAIR_W-1:0]    mem [DEPTH];
   logic [PW-1:0]        rd_ptr;
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr_nxt;
   logic [LW-1:0]        level_q;
   logic [LW-1:0]        level_nxt;
   logic                 valid_q;
   logic                 ovf_q;
   logic                 unf_q;
   logic [DATA_SIZE-1:0] out_l_q;
   logic [DATA_SIZE-1:0] out_r_q;

   logic                 pop;
   logic                 pop_empty;
   logic                 push_ok;
   logic                 push_drop;
   logic                 load_head;
   logic [PAIR_W-1:0]    in_pair;
   logic [PAIR_W-1:0]    head_nxt;

   always_comb begin
      in_pair    = {bus.Data_I_L, bus.Data_I_R};
      pop        = bus.ready_i & valid_q;
      pop_empty  = bus.ready_i & ~valid_q;
      push_ok    = bus.valid_strobe_I & ((level_q != FULL_LVL) | pop);
      push_drop  = bus.valid_strobe_I & ~push_ok;
      rd_ptr_nxt = rd_ptr + PW'(pop);

      level_nxt = level_q;
      if (push_ok && !pop) begin
         level_nxt = level_q + 1'b1;
      end else if (!push_ok && pop) begin
         level_nxt = level_q - 1'b1;
      end

      // The incoming pair becomes the head directly when nothing else is left
      // behind the pair being popped (or the FIFO was empty).
      if (level_q == LW'(pop)) begin
         head_nxt = in_pair;
      end else begin
         head_nxt = mem[rd_ptr_nxt];
      end
      load_head = (level_nxt != '0) & (pop | (level_q == '0));
   end

   // Storage is not reset; only written slots are ever presented.
   always_ff @(posedge clk_i) begin
      if (push_ok && !bus.clear_i) begin
         mem[wr_ptr] <= in_pair;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         level_q <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         out_l_q <= '0;
         out_r_q <= '0;
      end else if (bus.clear_i) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         level_q <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         rd_ptr  <= rd_ptr_nxt;
         wr_ptr  <= wr_ptr + PW'(push_ok);
         level_q <= level_nxt;
         valid_q <= (level_nxt != '0);
         ovf_q   <= ovf_q | push_drop;
         unf_q   <= unf_q | pop_empty;
         if (load_head) begin
            {out_l_q, out_r_q} <= head_nxt;
         end
      end
   end

   assign bus.Data_O_L    = out_l_q;
   assign bus.Data_O_R    = out_r_q;
   assign bus.valid_o     = valid_q;
   assign bus.level_o     = level_q;
   assign bus.overflow_o  = ovf_q;
   assign bus.underflow_o = unf_q;
endmodule

// File: tb/tb_student_iis_rx_fifo.sv
// Bench for the stereo RX FIFO: directed scenarios plus random traffic, checked by a
// queue-based reference model and a decoupled output monitor.
module tb_student_iis_rx_fifo;
   localparam int DATA_SIZE = 16;
   localparam int DEPTH     = 8;
   localparam int PAIR_W    = 2 * DATA_SIZE;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   student_iis_rx_fifo_if #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH)) bus ();

   student_iis_rx_fifo #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [PAIR_W-1:0] exp_q[$];
   int                model_lvl = 0;
   logic              model_ovf = 1'b0;
   logic              model_unf = 1'b0;
   logic [PAIR_W-1:0] last_shown = '0;
   logic              prev_valid = 1'b0;
   logic [PAIR_W-1:0] prev_pair = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at a drive slot (2 time units after a rising edge); returns at the next slot,
   // by which time the DUT outputs reflect this step.
   task automatic step(input logic s, input logic [DATA_SIZE-1:0] l, input logic [DATA_SIZE-1:0] r,
                       input logic rdy, input logic clr);
      logic pop;
      logic acc;
      bus.valid_strobe_I = s;
      bus.Data_I_L       = l;
      bus.Data_I_R       = r;
      bus.ready_i        = rdy;
      bus.clear_i        = clr;
      if (clr) begin
         exp_q.delete();
         model_lvl = 0;
         model_ovf = 1'b0;
         model_unf = 1'b0;
      end else begin
         pop = rdy && (model_lvl > 0);
         if (rdy && model_lvl == 0) model_unf = 1'b1;
         acc = s && ((model_lvl < DEPTH) || pop);
         if (s && !acc) model_ovf = 1'b1;
         if (acc) exp_q.push_back({l, r});
         model_lvl = model_lvl + int'(acc) - int'(pop);
      end
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      step(1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_valid"}, 64'(bus.valid_o), 64'd0);
      chk({tag, "_level"}, 64'(bus.level_o), 64'd0);
      chk({tag, "_ovf"}, 64'(bus.overflow_o), 64'd0);
      chk({tag, "_unf"}, 64'(bus.underflow_o), 64'd0);
      chk({tag, "_data"}, 64'({bus.Data_O_L, bus.Data_O_R}), 64'd0);
   endtask

   task automatic pulse_reset();
      bus.valid_strobe_I = 1'b0;
      bus.ready_i        = 1'b0;
      bus.clear_i        = 1'b0;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("rst_mid");
      exp_q.delete();
      model_lvl  = 0;
      model_ovf  = 1'b0;
      model_unf  = 1'b0;
      last_shown = '0;
      @(posedge clk); #2;
      @(posedge clk); #2;
      rst_n = 1'b1;
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         prev_valid = 1'b0;
         prev_pair  = '0;
      end else begin
         if (prev_valid && bus.ready_i && !bus.clear_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_order actual=pop_with_no_pending_pair expected=no_pop");
            end else begin
               chk("pop_pair", 64'(prev_pair), 64'(exp_q.pop_front()));
            end
         end
         chk("level", 64'(bus.level_o), 64'(model_lvl));
         chk("valid", 64'(bus.valid_o), 64'(model_lvl != 0));
         chk("overflow", 64'(bus.overflow_o), 64'(model_ovf));
         chk("underflow", 64'(bus.underflow_o), 64'(model_unf));
         if (model_lvl != 0 && exp_q.size() != 0) last_shown = exp_q[0];
         chk(model_lvl != 0 ? "head" : "hold", 64'({bus.Data_O_L, bus.Data_O_R}), 64'(last_shown));
         prev_valid = bus.valid_o;
         prev_pair  = {bus.Data_O_L, bus.Data_O_R};
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bus.valid_strobe_I = 1'b0;
      bus.Data_I_L       = '0;
      bus.Data_I_R       = '0;
      bus.ready_i        = 1'b0;
      bus.clear_i        = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check_zero_outputs("rst");
      rst_n = 1'b1;

      // single pair
      step(1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b0);
      chk("single_valid", 64'(bus.valid_o), 64'd1);
      chk("single_l", 64'(bus.Data_O_L), 64'h1234);
      chk("single_r", 64'(bus.Data_O_R), 64'hABCD);
      chk("single_level", 64'(bus.level_o), 64'd1);
      step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("single_pop_valid", 64'(bus.valid_o), 64'd0);
      chk("single_pop_level", 64'(bus.level_o), 64'd0);

      // fill past full, then drain
      for (int n = 0; n < 9; n++) step(1'b1, DATA_SIZE'(n), DATA_SIZE'(~n), 1'b0, 1'b0);
      chk("fill_level", 64'(bus.level_o), 64'd8);
      chk("fill_ovf", 64'(bus.overflow_o), 64'd1);
      for (int n = 0; n < 8; n++) step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("drain_level", 64'(bus.level_o), 64'd0);
      chk("drain_pending", 64'(exp_q.size()), 64'd0);

      // full with simultaneous push and pop
      step(1'b0, '0, '0, 1'b0, 1'b1);
      for (int n = 0; n < 8; n++) step(1'b1, DATA_SIZE'(16'h10 + n), DATA_SIZE'(16'h90 + n), 1'b0, 1'b0);
      step(1'b1, 16'h0055, 16'h00AA, 1'b1, 1'b0);
      chk("full_sim_level", 64'(bus.level_o), 64'd8);
      chk("full_sim_ovf", 64'(bus.overflow_o), 64'd0);
      chk("full_sim_head", 64'(bus.Data_O_L), 64'h11);
      for (int n = 0; n < 7; n++) step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("full_sim_last", 64'(bus.Data_O_L), 64'h55);
      step(1'b0, '0, '0, 1'b1, 1'b0);

      // underflow and clear
      step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("unf_flag", 64'(bus.underflow_o), 64'd1);
      chk("unf_level", 64'(bus.level_o), 64'd0);
      for (int n = 0; n < 5; n++) step(1'b1, DATA_SIZE'(16'h200 + n), DATA_SIZE'(16'h300 + n), 1'b0, 1'b0);
      chk("pre_clear_level", 64'(bus.level_o), 64'd5);
      step(1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b1);
      chk("clear_level", 64'(bus.level_o), 64'd0);
      chk("clear_valid", 64'(bus.valid_o), 64'd0);
      chk("clear_unf", 64'(bus.underflow_o), 64'd0);
      chk("clear_data_held", 64'(bus.Data_O_L), 64'h200);

      // random traffic with wrap-around
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 1)), DATA_SIZE'($urandom), DATA_SIZE'($urandom),
              1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 60) == 0));
      end
      step(1'b0, '0, '0, 1'b0, 1'b1);

      // reset mid-stream
      for (int n = 0; n < 3; n++) step(1'b1, DATA_SIZE'(16'h40 + n), DATA_SIZE'(16'h50 + n), 1'b0, 1'b0);
      chk("pre_rst_level", 64'(bus.level_o), 64'd3);
      pulse_reset();
      step(1'b1, 16'hBEEF, 16'h1234, 1'b0, 1'b0);
      chk("post_rst_valid", 64'(bus.valid_o), 64'd1);
      chk("post_rst_l", 64'(bus.Data_O_L), 64'hBEEF);
      chk("post_rst_level", 64'(bus.level_o), 64'd1);
      step(1'b0, '0, '0, 1'b1, 1'b0);
      idle();
      idle();

      // ---------------- report ----------------
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/student_iis_rx_fifo.md
STUDENT_IIS_RX_FIFO -- requirements
Module: student_iis_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16, meaning the width of one audio sample per channel.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the number of stereo sample pairs stored; legal values are powers of two from 2 to 64.
REQ-003 SHALL have port clk_i, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port Data_I_L, input, DATA_SIZE bits: left sample from the IIS receiver path.
REQ-006 SHALL have port Data_I_R, input, DATA_SIZE bits: right sample from the IIS receiver path.
REQ-007 SHALL have port valid_strobe_I, input, 1 bit: single-cycle push strobe qualifying Data_I_L and Data_I_R.
REQ-008 SHALL have port ready_i, input, 1 bit: the FIR consumer accepts the head pair.
REQ-009 SHALL have port clear_i, input, 1 bit: synchronous flush of contents and flags.
REQ-010 SHALL have port Data_O_L, output, DATA_SIZE bits: left sample of the head pair.
REQ-011 SHALL have port Data_O_R, output, DATA_SIZE bits: right sample of the head pair.
REQ-012 SHALL have port valid_o, output, 1 bit: the head pair is valid.
REQ-013 SHALL have port level_o, output, $clog2(DEPTH)+1 bits: number of stored pairs, including the head.
REQ-014 SHALL have port overflow_o, output, 1 bit: sticky flag indicating a dropped push.
REQ-015 SHALL have port underflow_o, output, 1 bit: sticky flag indicating ready_i was asserted while valid_o=0.

Function
REQ-016 SHALL store left/right as one atomic pair; the channels never separate or reorder.
REQ-017 SHALL be first-word-fall-through with registered outputs; a push into an empty FIFO at cycle N gives valid_o=1 and the pair on Data_O_* at N+1.
REQ-018 SHALL pop the head when valid_o=1 and ready_i=1 on the same edge; the next pair, if any, appears on the following cycle with no bubble.
REQ-019 SHALL keep Data_O_* stable while valid_o=1 and ready_i=0.
REQ-020 SHALL hold Data_O_* at their last value when valid_o=0, never X.
REQ-021 SHALL use read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH without special-casing.
REQ-022 SHALL accept a push when level_o<DEPTH.
REQ-023 SHALL accept a push when level_o=DEPTH and a pop occurs in the same cycle; level_o is then unchanged.
REQ-024 SHALL drop a push when level_o=DEPTH with no pop, leave stored data untouched, and set overflow_o=1.
REQ-025 SHALL update level_o as follows for simultaneous push and pop with level_o>=1: level unchanged, output advances, new pair written.
REQ-026 SHALL, for a simultaneous push and ready_i with level_o=0, take the push, ignore the pop, and set underflow_o=1.
REQ-027 SHALL, when ready_i=1 and valid_o=0, make no pointer change and set underflow_o=1.
REQ-028 SHALL make overflow_o and underflow_o sticky until clear_i or reset.
REQ-029 SHALL treat clear_i=1 as having priority over push and pop that cycle: next cycle level_o=0, valid_o=0, flags=0, pointers=0, Data_O_* unchanged.
REQ-030 SHALL keep level_o in the range 0..DEPTH at all times.

Reset
REQ-031 SHALL, while rst_ni=0, asynchronously force valid_o=0, level_o=0, overflow_o=0, underflow_o=0, Data_O_L=0, Data_O_R=0, and both pointers to 0.
REQ-032 SHALL discard all contents when reset is asserted mid-operation; the first push after release behaves as a push into an empty FIFO per REQ-017.
REQ-033 SHALL NOT require the storage array to be reset.

Verification
REQ-034 SHALL cover single pair: push L=0x1234, R=0xABCD with ready_i=0 -> next cycle valid_o=1, Data_O=0x1234/0xABCD, level_o=1; pulse ready_i -> valid_o=0, level_o=0.
REQ-035 SHALL cover fill/overflow (DEPTH=8): 9 pushes of L=n, R=~n, ready_i=0 -> level_o=8, overflow_o=1; drain -> L sequence 0..7, pair 8 absent.
REQ-036 SHALL cover full and simultaneous: at level 8 push L=0x55 with ready_i=1 -> level_o stays 8, overflow_o=0, 0x55 emerges last.
REQ-037 SHALL cover wrap-around: 20 push/pop cycles with a random ready_i pattern -> output order matches a reference queue, level_o matches the model every cycle.
REQ-038 SHALL cover underflow and clear: ready_i=1 on empty -> underflow_o=1, no pointer change; clear_i at level 5 -> level_o=0, valid_o=0, flags=0.
REQ-039 SHALL cover reset mid-stream: rst_ni low at level 3 -> all outputs 0 immediately; push after release -> appears after 1 cycle.
